inst_fetch_ras: RTL



---
 rtl/inst_fetch_ras_if.sv | 36 +++
 rtl/inst_fetch_ras.sv | 103 ++++++++++
 2 files changed

// File: rtl/inst_fetch_ras_if.sv
// Fetch-control bundle between the decoder/ALU side and the PC unit.
// Carries branch/call/return controls in and the PC and RAS status out.
interface inst_fetch_ras_if #(
    parameter int PC_W      = 10,
    parameter int OFF_W     = 8,
    parameter int RAS_DEPTH = 4
);
    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

    logic             Start;
    logic [1:0]       ProgSel;
    logic             Stall;
    logic             BranchAbs;
    logic             BranchRelEn;
    logic             ALU_flag;
    logic [OFF_W-1:0] Offset;
    logic             Call;
    logic             Ret;
    logic [PC_W-1:0]  Target;
    logic [PC_W-1:0]  ProgCtr;
    logic [CNT_W-1:0] RasCount;
    logic             RasOvf;
    logic             RasUnf;

    modport master (
        output Start, ProgSel, Stall, BranchAbs, BranchRelEn,
        output ALU_flag, Offset, Call, Ret, Target,
        input  ProgCtr, RasCount, RasOvf, RasUnf
    );

    modport slave (
        input  Start, ProgSel, Stall, BranchAbs, BranchRelEn,
        input  ALU_flag, Offset, Call, Ret, Target,
        output ProgCtr, RasCount, RasOvf, RasUnf
    );
endinterface

// File: rtl/inst_fetch_ras.sv
// Program counter with absolute/relative branches, call/return stack,
// stall and per-program start addresses.
module inst_fetch_ras #(
    parameter int PC_W       = 10,
    parameter int OFF_W      = 8,
    parameter int RAS_DEPTH  = 4,
    parameter int PROG0_BASE = 0,
    parameter int PROG1_BASE = 0,
    parameter int PROG2_BASE = 0
) (
    input logic              Clk,
    input logic              Reset,
    inst_fetch_ras_if.slave  bus
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  r_pc;
    logic [CNT_W-1:0] r_cnt;
    logic [PTR_W-1:0] r_ptr;
    logic             r_ovf;
    logic             r_unf;
    logic [PC_W-1:0]  r_ras [RAS_DEPTH];

    logic [PC_W-1:0]  w_pc_inc;
    logic [PC_W-1:0]  w_off_ext;
    logic [PC_W-1:0]  w_base;
    logic [PTR_W-1:0] w_ptr_dec;
    logic             w_full;
    logic             w_empty;
    logic             w_ret;
    logic             w_push;

    assign w_pc_inc  = r_pc + PC_W'(1);
    assign w_off_ext = PC_W'($signed(bus.Offset));
    assign w_ptr_dec = r_ptr - PTR_W'(1);
    assign w_full    = (r_cnt == CNT_W'(RAS_DEPTH));
    assign w_empty   = (r_cnt == '0);
    assign w_ret     = !bus.Start && !bus.Stall && bus.Ret;
    assign w_push    = !bus.Start && !bus.Stall && !bus.Ret && bus.Call;

    // ProgSel=3 is not a real program and falls back to program 0
    always_comb begin
        w_base = PC_W'(PROG0_BASE);
        case (bus.ProgSel)
            2'd1:    w_base = PC_W'(PROG1_BASE);
            2'd2:    w_base = PC_W'(PROG2_BASE);
            default: w_base = PC_W'(PROG0_BASE);
        endcase
    end

    // Stack storage needs no reset; the count decides what is valid
    always_ff @(posedge Clk) begin
        if (w_push)
            r_ras[r_ptr] <= w_pc_inc;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_pc  <= '0;
            r_cnt <= '0;
            r_ptr <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (bus.Start) begin
            r_pc  <= w_base;
            r_cnt <= '0;
            r_ptr <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (bus.Stall) begin
            r_pc  <= r_pc;
        end else if (w_ret) begin
            if (!w_empty) begin
                r_pc  <= r_ras[w_ptr_dec];
                r_cnt <= r_cnt - CNT_W'(1);
                r_ptr <= w_ptr_dec;
            end else begin
                r_pc  <= w_pc_inc;
                r_unf <= 1'b1;
            end
        end else if (w_push) begin
            r_pc  <= bus.Target;
            r_ptr <= r_ptr + PTR_W'(1);
            // A full stack overwrites its oldest entry and stays full
            if (w_full)
                r_ovf <= 1'b1;
            else
                r_cnt <= r_cnt + CNT_W'(1);
        end else if (bus.BranchAbs) begin
            r_pc  <= bus.Target;
        end else if (bus.BranchRelEn && bus.ALU_flag) begin
            r_pc  <= r_pc + w_off_ext;
        end else begin
            r_pc  <= w_pc_inc;
        end
    end

    assign bus.ProgCtr  = r_pc;
    assign bus.RasCount = r_cnt;
    assign bus.RasOvf   = r_ovf;
    assign bus.RasUnf   = r_unf;
endmodule
